// File: rtl/pll_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_supervisor_if
// Groups the PLL-facing and domain-facing signals of the PLL supervisor.
//   pll_locked   : raw PLL LOCK, asynchronous to the supervisor clock
//   pll_rst      : active-high reset to the PLL RST pin
//   domain_rst_n : active-low reset request per downstream clock domain
//   clocks_ok    : high only while every domain is out of reset
//   fault        : sticky lock-failure indication
//   relock_count : saturating count of lock losses seen in RUN/RELEASE
// Modports:
//   master : the supervisor (drives resets/status, samples pll_locked)
//   slave  : the PLL/board side (drives pll_locked, observes the rest)
// ---------------------------------------------------------------------------
interface pll_supervisor_if #(
    parameter int NUM_DOMAINS = 2
);
    logic                   pll_locked;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   clocks_ok;
    logic                   fault;
    logic [7:0]             relock_count;

    modport master (
        input  pll_locked,
        output pll_rst,
        output domain_rst_n,
        output clocks_ok,
        output fault,
        output relock_count
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  domain_rst_n,
        input  clocks_ok,
        input  fault,
        input  relock_count
    );
endinterface

// File: rtl/pll_supervisor.sv
// ---------------------------------------------------------------------------
// pll_supervisor
// Pulses the PLL reset, waits for a stable lock (with timeout and bounded
// retries), then releases the downstream domain resets one at a time with a
// fixed stagger. A lock loss while releasing or running puts every domain
// back into reset and restarts the PLL; repeated lock timeouts end in a
// sticky FAULT state that only reset_n clears.
// Ports:
//   clkin   : free-running board reference, the only clock
//   reset_n : asynchronous active-low reset
//   sup     : pll_supervisor_if.master (pll_locked in; pll_rst,
//             domain_rst_n, clocks_ok, fault, relock_count out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module pll_supervisor #(
    parameter int NUM_DOMAINS         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int STAGGER_CYCLES      = 8
) (
    input  logic                clkin,
    input  logic                reset_n,
    pll_supervisor_if.master    sup
);

    localparam int STG_MAX = STAGGER_CYCLES * NUM_DOMAINS;
    localparam int RST_W   = $clog2(PLL_RST_CYCLES + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int RTY_W   = $clog2(MAX_RETRIES + 1);
    localparam int STG_W   = $clog2(STG_MAX + 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync_meta_q, sync_meta_d;
    logic                   lock_s_q, lock_s_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]       stable_cnt_q, stable_cnt_d;
    logic [TMO_W-1:0]       timeout_cnt_q, timeout_cnt_d;
    logic [RTY_W-1:0]       retry_cnt_q, retry_cnt_d;
    logic [STG_W-1:0]       stagger_cnt_q, stagger_cnt_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] domain_rst_n_q, domain_rst_n_d;
    logic                   clocks_ok_q, clocks_ok_d;
    logic                   fault_q, fault_d;
    logic [7:0]             relock_count_q, relock_count_d;

    logic [STG_W-1:0]       stagger_next;
    logic                   lock_lost;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d        = state_q;
        // Two-flop synchroniser: only lock_s_q is ever used for decisions.
        sync_meta_d    = sup.pll_locked;
        lock_s_d       = sync_meta_q;
        // Per-state counters idle at zero outside their own state, so every
        // entry into a state starts its counter from zero.
        rst_cnt_d      = '0;
        stable_cnt_d   = '0;
        timeout_cnt_d  = '0;
        stagger_cnt_d  = '0;
        retry_cnt_d    = retry_cnt_q;
        pll_rst_d      = pll_rst_q;
        domain_rst_n_d = domain_rst_n_q;
        clocks_ok_d    = clocks_ok_q;
        fault_d        = fault_q;
        relock_count_d = relock_count_q;
        stagger_next   = stagger_cnt_q + 1'b1;
        lock_lost      = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s_q;

        if (lock_lost) begin
            // Lock loss outranks any pending release in the same cycle.
            state_d        = ST_PLL_RST;
            pll_rst_d      = 1'b1;
            domain_rst_n_d = '0;
            clocks_ok_d    = 1'b0;
            if (relock_count_q != 8'hFF) begin
                relock_count_d = relock_count_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    pll_rst_d      = 1'b1;
                    domain_rst_n_d = '0;
                    clocks_ok_d    = 1'b0;
                    if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) begin
                        state_d   = ST_WAIT_LOCK;
                        pll_rst_d = 1'b0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                    if (lock_s_q) begin
                        stable_cnt_d = stable_cnt_q + 1'b1;
                    end
                    // Reaching the stable count is checked first, so a lock
                    // that completes on the timeout cycle is still accepted.
                    if (lock_s_q && (stable_cnt_q == STB_W'(LOCK_STABLE_CYCLES - 1))) begin
                        state_d       = ST_RELEASE;
                        retry_cnt_d   = '0;
                        stable_cnt_d  = '0;
                        timeout_cnt_d = '0;
                    end else if (timeout_cnt_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_cnt_d   = retry_cnt_q + 1'b1;
                        pll_rst_d     = 1'b1;
                        stable_cnt_d  = '0;
                        timeout_cnt_d = '0;
                        if (retry_cnt_q == RTY_W'(MAX_RETRIES - 1)) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = ST_PLL_RST;
                        end
                    end
                end

                ST_RELEASE: begin
                    // Domain i is released when the count since entry reaches
                    // STAGGER_CYCLES*(i+1); earlier releases are held.
                    stagger_cnt_d = stagger_next;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (stagger_next == STG_W'(STAGGER_CYCLES * (i + 1))) begin
                            domain_rst_n_d[i] = 1'b1;
                        end
                    end
                    if (stagger_next == STG_W'(STG_MAX)) begin
                        state_d       = ST_RUN;
                        clocks_ok_d   = 1'b1;
                        stagger_cnt_d = '0;
                    end
                end

                ST_RUN: begin
                    domain_rst_n_d = '1;
                    clocks_ok_d    = 1'b1;
                    pll_rst_d      = 1'b0;
                end

                ST_FAULT: begin
                    pll_rst_d      = 1'b1;
                    domain_rst_n_d = '0;
                    clocks_ok_d    = 1'b0;
                    fault_d        = 1'b1;
                end

                default: begin
                    state_d        = ST_PLL_RST;
                    pll_rst_d      = 1'b1;
                    domain_rst_n_d = '0;
                    clocks_ok_d    = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_PLL_RST;
            sync_meta_q    <= 1'b0;
            lock_s_q       <= 1'b0;
            rst_cnt_q      <= '0;
            stable_cnt_q   <= '0;
            timeout_cnt_q  <= '0;
            retry_cnt_q    <= '0;
            stagger_cnt_q  <= '0;
            pll_rst_q      <= 1'b1;
            domain_rst_n_q <= '0;
            clocks_ok_q    <= 1'b0;
            fault_q        <= 1'b0;
            relock_count_q <= '0;
        end else begin
            state_q        <= state_d;
            sync_meta_q    <= sync_meta_d;
            lock_s_q       <= lock_s_d;
            rst_cnt_q      <= rst_cnt_d;
            stable_cnt_q   <= stable_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            retry_cnt_q    <= retry_cnt_d;
            stagger_cnt_q  <= stagger_cnt_d;
            pll_rst_q      <= pll_rst_d;
            domain_rst_n_q <= domain_rst_n_d;
            clocks_ok_q    <= clocks_ok_d;
            fault_q        <= fault_d;
            relock_count_q <= relock_count_d;
        end
    end

    assign sup.pll_rst      = pll_rst_q;
    assign sup.domain_rst_n = domain_rst_n_q;
    assign sup.clocks_ok    = clocks_ok_q;
    assign sup.fault        = fault_q;
    assign sup.relock_count = relock_count_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_supervisor
// Directed bench for pll_supervisor with NUM_DOMAINS=2, PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=100, MAX_RETRIES=3,
// STAGGER_CYCLES=8. Inputs change and outputs are sampled on the falling
// edge; cycle index n means the falling edge after the n-th rising edge
// following reset release.
// ---------------------------------------------------------------------------
module tb_pll_supervisor;

    logic clkin;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   cur;

    pll_supervisor_if #(.NUM_DOMAINS(2)) sup_if ();

    pll_supervisor #(
        .NUM_DOMAINS         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (16),
        .LOCK_TIMEOUT_CYCLES (100),
        .MAX_RETRIES         (3),
        .STAGGER_CYCLES      (8)
    ) dut (
        .clkin   (clkin),
        .reset_n (reset_n),
        .sup     (sup_if)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to falling edge n after reset release.
    task automatic at(input int n);
        while (cur < n) begin
            @(negedge clkin);
            cur++;
        end
    endtask

    task automatic do_reset(input logic lock);
        @(negedge clkin);
        reset_n = 1'b0;
        sup_if.pll_locked = lock;
        repeat (2) @(negedge clkin);
        reset_n = 1'b1;
        cur = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},  32'(sup_if.pll_rst),      32'd1);
        check({tag, "_dom"},      32'(sup_if.domain_rst_n), 32'd0);
        check({tag, "_ok"},       32'(sup_if.clocks_ok),    32'd0);
        check({tag, "_fault"},    32'(sup_if.fault),        32'd0);
        check({tag, "_relock"},   32'(sup_if.relock_count), 32'd0);
    endtask

    initial begin
        logic bound_ok;
        int   w;
        vectors     = 0;
        miscompares = 0;
        cur         = 0;
        bound_ok    = 1'b1;
        reset_n     = 1'b0;
        sup_if.pll_locked = 1'b1;

        // Held in reset across clock edges.
        repeat (2) @(negedge clkin);
        check_reset_values("rst_init");

        // ---- Clean lock: RELEASE entered at edge 20 ----
        reset_n = 1'b1;
        cur = 0;
        at(3);  check("clean_pll_rst_n3",  32'(sup_if.pll_rst), 32'd1);
        at(4);  check("clean_pll_rst_n4",  32'(sup_if.pll_rst), 32'd0);
        at(27); check("clean_dom_n27",     32'(sup_if.domain_rst_n), 32'b00);
        at(28); check("clean_dom_n28",     32'(sup_if.domain_rst_n), 32'b01);
        at(35); check("clean_dom_n35",     32'(sup_if.domain_rst_n), 32'b01);
                check("clean_ok_n35",      32'(sup_if.clocks_ok), 32'd0);
        at(36); check("clean_dom_n36",     32'(sup_if.domain_rst_n), 32'b11);
                check("clean_ok_n36",      32'(sup_if.clocks_ok), 32'd1);
                check("clean_relock",      32'(sup_if.relock_count), 32'd0);
                check("clean_pll_rst_run", 32'(sup_if.pll_rst), 32'd0);

        // ---- Glitch at stable count 10: lock_s low only at edge 16 ----
        do_reset(1'b1);
        at(14); sup_if.pll_locked = 1'b0;
        at(15); sup_if.pll_locked = 1'b1;
        at(28); check("glitch_dom_n28", 32'(sup_if.domain_rst_n), 32'b00);
        at(40); check("glitch_dom_n40", 32'(sup_if.domain_rst_n), 32'b00);
        at(41); check("glitch_dom_n41", 32'(sup_if.domain_rst_n), 32'b01);
        at(49); check("glitch_dom_n49", 32'(sup_if.domain_rst_n), 32'b11);
                check("glitch_ok_n49",  32'(sup_if.clocks_ok), 32'd1);

        // ---- Loss in RUN: drop at 52, detected at edge 55 ----
        at(52); sup_if.pll_locked = 1'b0;
        at(54); check("run_loss_dom_n54", 32'(sup_if.domain_rst_n), 32'b11);
        at(55); check("run_loss_dom_n55", 32'(sup_if.domain_rst_n), 32'b00);
                check("run_loss_ok_n55",  32'(sup_if.clocks_ok), 32'd0);
                check("run_loss_relock",  32'(sup_if.relock_count), 32'd1);
                check("run_loss_pll_rst", 32'(sup_if.pll_rst), 32'd1);
                sup_if.pll_locked = 1'b1;
        at(58); check("relock_pll_rst_n58", 32'(sup_if.pll_rst), 32'd1);
        at(59); check("relock_pll_rst_n59", 32'(sup_if.pll_rst), 32'd0);
        at(82); check("relock_dom_n82",     32'(sup_if.domain_rst_n), 32'b00);
        at(83); check("relock_dom_n83",     32'(sup_if.domain_rst_n), 32'b01);
        at(90); check("relock_dom_n90",     32'(sup_if.domain_rst_n), 32'b01);
        at(91); check("relock_dom_n91",     32'(sup_if.domain_rst_n), 32'b11);
                check("relock_ok_n91",      32'(sup_if.clocks_ok), 32'd1);
                check("relock_count_n91",   32'(sup_if.relock_count), 32'd1);

        // ---- Loss in RELEASE: second loss at 98, RELEASE at 118, drop at 127 ----
        at(95);  sup_if.pll_locked = 1'b0;
        at(98);  check("loss2_dom_n98",    32'(sup_if.domain_rst_n), 32'b00);
                 check("loss2_relock",     32'(sup_if.relock_count), 32'd2);
                 sup_if.pll_locked = 1'b1;
        at(125); check("rel_loss_dom_n125", 32'(sup_if.domain_rst_n), 32'b00);
        at(126); check("rel_loss_dom_n126", 32'(sup_if.domain_rst_n), 32'b01);
        at(127); sup_if.pll_locked = 1'b0;
        at(129); check("rel_loss_dom_n129", 32'(sup_if.domain_rst_n), 32'b01);
        at(130); check("rel_loss_dom_n130", 32'(sup_if.domain_rst_n), 32'b00);
                 check("rel_loss_relock",   32'(sup_if.relock_count), 32'd3);
                 check("rel_loss_ok_n130",  32'(sup_if.clocks_ok), 32'd0);
        at(134); check("rel_loss_dom_n134", 32'(sup_if.domain_rst_n), 32'b00);
        at(140); check("rel_loss_dom_n140", 32'(sup_if.domain_rst_n), 32'b00);

        // ---- No lock: timeouts at 104, 208, 312; FAULT from 312 ----
        do_reset(1'b0);
        at(3);   check("nolock_p1_n3",   32'(sup_if.pll_rst), 32'd1);
        at(4);   check("nolock_p1_n4",   32'(sup_if.pll_rst), 32'd0);
        at(103); check("nolock_n103",    32'(sup_if.pll_rst), 32'd0);
        at(104); check("nolock_p2_n104", 32'(sup_if.pll_rst), 32'd1);
        at(107); check("nolock_p2_n107", 32'(sup_if.pll_rst), 32'd1);
        at(108); check("nolock_p2_n108", 32'(sup_if.pll_rst), 32'd0);
        at(207); check("nolock_n207",    32'(sup_if.pll_rst), 32'd0);
        at(208); check("nolock_p3_n208", 32'(sup_if.pll_rst), 32'd1);
        at(211); check("nolock_p3_n211", 32'(sup_if.pll_rst), 32'd1);
        at(212); check("nolock_p3_n212", 32'(sup_if.pll_rst), 32'd0);
        at(311); check("nolock_n311",    32'(sup_if.pll_rst), 32'd0);
                 check("nolock_fault_n311", 32'(sup_if.fault), 32'd0);
        at(312); check("fault_pll_rst_n312", 32'(sup_if.pll_rst), 32'd1);
                 check("fault_n312",         32'(sup_if.fault), 32'd1);
        at(420); check("fault_pll_rst_n420", 32'(sup_if.pll_rst), 32'd1);
                 check("fault_n420",         32'(sup_if.fault), 32'd1);
                 check("fault_dom_n420",     32'(sup_if.domain_rst_n), 32'b00);

        // reset_n pulse clears the sticky fault immediately.
        #2 reset_n = 1'b0;
        #1 check("fault_clear", 32'(sup_if.fault), 32'd0);
        sup_if.pll_locked = 1'b1;
        @(negedge clkin);
        reset_n = 1'b1;

        // ---- relock_count saturation: 256 losses, each during RELEASE ----
        for (int k = 0; k < 256; k++) begin
            w = 0;
            while (sup_if.domain_rst_n[0] !== 1'b1 && w < 200) begin
                @(negedge clkin);
                w++;
            end
            if (w >= 200) bound_ok = 1'b0;
            sup_if.pll_locked = 1'b0;
            repeat (4) @(negedge clkin);
            sup_if.pll_locked = 1'b1;
        end
        check("sat_wait_bound", 32'(bound_ok), 32'd1);
        w = 0;
        while (sup_if.clocks_ok !== 1'b1 && w < 200) begin
            @(negedge clkin);
            w++;
        end
        check("sat_run_ok",  32'(sup_if.clocks_ok), 32'd1);
        check("sat_run_dom", 32'(sup_if.domain_rst_n), 32'b11);
        check("sat_relock",  32'(sup_if.relock_count), 32'd255);

        // ---- Async reset mid-RUN, between clock edges ----
        @(negedge clkin);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clkin);
        reset_n = 1'b1;
        cur = 0;
        at(3); check("rerst_pll_rst_n3", 32'(sup_if.pll_rst), 32'd1);
        at(4); check("rerst_pll_rst_n4", 32'(sup_if.pll_rst), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
